rgen_response_mux_wait: RTL and testbench
=========================================

// Module: rgen_response_mux_wait
// PURPOSE
//  Register-block response multiplexer with per-register wait-state support.
//  Sits between the bus-protocol front end and the register array: picks the selected register's read
//  data once that register signals ready, then returns one registered response pulse.
//  Adds multi-hit detection, a wait-state timeout and write-data masking.
// PARAMETERS
//  DATA_WIDTH       32  width of read data bus
//  TOTAL_REGISTERS  1   number of registers (select/ready/data vectors); >=1
//  TIMEOUT_CYCLES   0   max WAIT cycles before SLVERR; 0 = timeout disabled
// PORTS
//  clk                   in   1                           clock
//  rst_n                 in   1                           asynchronous active-low reset
//  i_command_valid       in   1                           command pending; held high until o_response_ready seen
//  i_command_write       in   1                           1 = write access, 0 = read; stable while valid
//  i_register_select     in   TOTAL_REGISTERS             one-hot address decode result; stable while valid
//  i_register_ready      in   TOTAL_REGISTERS             register i has data/write complete
//  i_register_read_data  in   DATA_WIDTH x TOTAL_REGISTERS  unpacked array [TOTAL_REGISTERS], per-register read data
//  o_response_ready      out  1                           one-cycle response pulse
//  o_read_data           out  DATA_WIDTH                  response read data, valid with o_response_ready
//  o_status              out  2                           00 OKAY, 01 SLVERR, 10 EXOKAY (never driven), 11 reserved
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, o_response_ready=0, o_read_data=0, o_status=2'b00. All outputs are registered.
//  Decode, evaluated combinationally each cycle:
//   - hit = exactly one select bit set
//   - multi = more than one set
//   - none = zero set
//   - sel_ready = |(select & ready)
//  IDLE:
//   - no i_command_valid -> stay
//   - valid & (none | multi) -> RESPOND; status 01, data 0
//   - valid & hit & sel_ready -> RESPOND; status 00, data = AND-OR mux of selected data (0 if write)
//   - valid & hit & !sel_ready -> WAIT, counter=0
//  WAIT:
//   - valid dropped -> IDLE, counter=0, no response (abort)
//   - sel_ready -> RESPOND; capture as in IDLE
//   - else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> RESPOND; status 01, data 0
//   - else counter++
//  RESPOND: o_response_ready=1 with captured data/status for exactly one cycle; i_command_valid ignored;
//   next state IDLE, outputs return to 0.
//   Master drops valid on the cycle after the pulse; a valid still high in IDLE is a new command.
//  Latency: min 1 cycle (valid edge -> pulse visible next cycle); with W wait cycles, W+1.
//   Timeout: pulse TIMEOUT_CYCLES+1 cycles after valid.
//  Counter width $clog2(TIMEOUT_CYCLES+1), min 1; saturates, never wraps; unused when TIMEOUT_CYCLES=0.
//  Writes: o_read_data forced 0; status rules identical to reads.
//  TOTAL_REGISTERS==1: multi impossible; hit = select[0]; mux degenerates to data[0].
//  Data/select sampled only on the capture edge; changes during WAIT on non-selected lanes have no effect.
//  rst_n asserted in any state: immediate return to reset values, pending command dropped.
// TESTING
//  1 N=4, select=0010, ready=1111, data[1]=32'hDEAD_BEEF, read -> pulse 1 cycle after valid, data DEADBEEF, status 00
//  2 N=4, select=0000 -> pulse next cycle, data 0, status 01; select=0110 -> same SLVERR, data 0
//  3 select=0100, ready[2] rises after 3 cycles, data 32'h1234_5678 -> pulse 4 cycles after valid, status 00
//  4 TIMEOUT_CYCLES=8, ready never -> pulse at cycle 9, status 01, data 0; TIMEOUT=0 -> no pulse after 100 cycles
//  5 write, select=0001 ready=1 data=FFFF_FFFF -> pulse, data 0, status 00
//  6 valid dropped in WAIT; rst_n low mid-WAIT -> IDLE, no pulse; next command answered normally

Source files
------------

// File: rtl/rgen_response_mux_wait.sv
// Register-block response mux: waits for the selected register's ready, then
// returns one registered response pulse with read data and OKAY/SLVERR status.
module rgen_response_mux_wait #(
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_command_valid,
  input  logic                       i_command_write,
  input  logic [TOTAL_REGISTERS-1:0] i_register_select,
  input  logic [TOTAL_REGISTERS-1:0] i_register_ready,
  input  logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS],
  output logic                       o_response_ready,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic [1:0]                 o_status
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_SLVERR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_counter;

  logic                   w_none;
  logic                   w_multi;
  logic                   w_hit;
  logic                   w_sel_ready;
  logic [DATA_WIDTH-1:0]  w_mux;
  logic [DATA_WIDTH-1:0]  w_cap_data;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_none      = (i_register_select == '0);
  assign w_multi     = |(i_register_select & (i_register_select - TOTAL_REGISTERS'(1)));
  assign w_hit       = !w_none && !w_multi;
  assign w_sel_ready = |(i_register_select & i_register_ready);

  always_comb begin
    w_mux = '0;
    for (int unsigned i = 0; i < TOTAL_REGISTERS; i++) begin
      w_mux = w_mux | (i_register_read_data[i] & {DATA_WIDTH{i_register_select[i]}});
    end
  end

  assign w_cap_data = i_command_write ? '0 : w_mux;

  // Outputs default to zero every cycle, so the response lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_counter        <= '0;
      o_response_ready <= 1'b0;
      o_read_data      <= '0;
      o_status         <= ST_OKAY;
    end else begin
      o_response_ready <= 1'b0;
      o_read_data      <= '0;
      o_status         <= ST_OKAY;
      case (r_state)
        S_IDLE: begin
          if (i_command_valid) begin
            if (!w_hit) begin
              r_state          <= S_RESPOND;
              o_response_ready <= 1'b1;
              o_status         <= ST_SLVERR;
            end else if (w_sel_ready) begin
              r_state          <= S_RESPOND;
              o_response_ready <= 1'b1;
              o_read_data      <= w_cap_data;
            end else begin
              r_state   <= S_WAIT;
              r_counter <= '0;
            end
          end
        end
        S_WAIT: begin
          if (!i_command_valid) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
          end else if (w_sel_ready) begin
            r_state          <= S_RESPOND;
            o_response_ready <= 1'b1;
            o_read_data      <= w_cap_data;
          end else if (TO_EN && (r_counter == CNT_LAST)) begin
            r_state          <= S_RESPOND;
            o_response_ready <= 1'b1;
            o_status         <= ST_SLVERR;
          end else if (r_counter != CNT_MAX) begin
            r_counter <= r_counter + CW'(1);
          end
        end
        S_RESPOND: begin
          r_state   <= S_IDLE;
          r_counter <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgen_response_mux_wait.sv
// Bench for rgen_response_mux_wait: directed scenarios plus randomized commands
// checked against a latency/response model derived from the command rules.
module tb_rgen_response_mux_wait;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          valid_nt = 1'b0;
  logic          wr = 1'b0;
  logic [N-1:0]  sel = '0;
  logic [N-1:0]  rdy = '0;
  logic [DW-1:0] rdata [N];

  logic          resp, resp_nt;
  logic [DW-1:0] rd, rd_nt;
  logic [1:0]    st, st_nt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgen_response_mux_wait #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_command_valid(valid), .i_command_write(wr),
    .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata),
    .o_response_ready(resp), .o_read_data(rd), .o_status(st)
  );

  rgen_response_mux_wait #(.DATA_WIDTH(DW), .TOTAL_REGISTERS(N), .TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .i_command_valid(valid_nt), .i_command_write(wr),
    .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata),
    .o_response_ready(resp_nt), .o_read_data(rd_nt), .o_status(st_nt)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: response latency and contents from select count, ready delay d
  // (cycles after valid before ready; -1 = never) and the timeout limit.
  function automatic void model(input logic [N-1:0] s, input logic w, input int d,
                                output int lat, output logic [DW-1:0] od, output logic [1:0] os);
    if ($countones(s) != 1) begin
      lat = 1; od = '0; os = 2'b01;
    end else if (d >= 0 && d <= TO) begin
      lat = d + 1; os = 2'b00;
      od = w ? '0 : rdata[$clog2(s)];
    end else begin
      lat = TO + 1; od = '0; os = 2'b01;
    end
  endfunction

  // Issues one command to dut; returns pulse latency (-1 if none), captured
  // data/status, and o_response_ready one cycle after the pulse.
  task automatic drive_cmd(input logic [N-1:0] s, input logic w, input int d,
                           output int lat, output logic [DW-1:0] od, output logic [1:0] os,
                           output logic after);
    logic [N-1:0] noise;
    noise = N'($urandom);
    sel = s; wr = w;
    rdy = (noise & ~s) | ((d == 0) ? s : '0);
    valid = 1'b1;
    lat = -1; od = '0; os = 2'b00;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (resp) begin
        lat = c; od = rd; os = st;
        break;
      end
      if (c == d) rdy = rdy | s;
    end
    valid = 1'b0; sel = '0; rdy = '0; wr = 1'b0;
    @(posedge clk); #1;
    after = resp;
  endtask

  task automatic test_reset();
    foreach (rdata[i]) rdata[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (resp !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", resp); end
    n_vec++; if (rd !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", rd); end
    n_vec++; if (st !== 2'b00) begin n_err++; $display("FAIL reset_status got %b want 00", st); end
    n_vec++; if (resp_nt !== 1'b0) begin n_err++; $display("FAIL reset_ready_nt got %b want 0", resp_nt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_hit();
    int lat; logic [DW-1:0] od; logic [1:0] os; logic after;
    rdata[1] = 32'hDEAD_BEEF;
    drive_cmd(4'b0010, 1'b0, 0, lat, od, os, after);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL hit_latency got %0d want 1", lat); end
    n_vec++; if (od !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hit_data got %h want deadbeef", od); end
    n_vec++; if (os !== 2'b00) begin n_err++; $display("FAIL hit_status got %b want 00", os); end
    n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL hit_single_pulse got %b want 0", after); end
  endtask

  task automatic test_decode_error();
    int lat; logic [DW-1:0] od; logic [1:0] os; logic after;
    logic [N-1:0] pats [2];
    pats[0] = 4'b0000; pats[1] = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      drive_cmd(pats[k], 1'b0, 0, lat, od, os, after);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL decerr_latency sel=%b got %0d want 1", pats[k], lat); end
      n_vec++; if (od !== '0) begin n_err++; $display("FAIL decerr_data sel=%b got %h want 0", pats[k], od); end
      n_vec++; if (os !== 2'b01) begin n_err++; $display("FAIL decerr_status sel=%b got %b want 01", pats[k], os); end
    end
  endtask

  task automatic test_wait();
    int lat; logic [DW-1:0] od; logic [1:0] os; logic after;
    rdata[2] = 32'h1234_5678;
    drive_cmd(4'b0100, 1'b0, 3, lat, od, os, after);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wait_latency got %0d want 4", lat); end
    n_vec++; if (od !== 32'h1234_5678) begin n_err++; $display("FAIL wait_data got %h want 12345678", od); end
    n_vec++; if (os !== 2'b00) begin n_err++; $display("FAIL wait_status got %b want 00", os); end
  endtask

  task automatic test_write();
    int lat; logic [DW-1:0] od; logic [1:0] os; logic after;
    rdata[0] = 32'hFFFF_FFFF;
    drive_cmd(4'b0001, 1'b1, 0, lat, od, os, after);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL write_latency got %0d want 1", lat); end
    n_vec++; if (od !== '0) begin n_err++; $display("FAIL write_data got %h want 0", od); end
    n_vec++; if (os !== 2'b00) begin n_err++; $display("FAIL write_status got %b want 00", os); end
  endtask

  task automatic test_timeout();
    int lat; int pulses; logic [DW-1:0] od; logic [1:0] os; logic after;
    drive_cmd(4'b1000, 1'b0, -1, lat, od, os, after);
    n_vec++; if (lat !== TO + 1) begin n_err++; $display("FAIL timeout_latency got %0d want %0d", lat, TO + 1); end
    n_vec++; if (od !== '0) begin n_err++; $display("FAIL timeout_data got %h want 0", od); end
    n_vec++; if (os !== 2'b01) begin n_err++; $display("FAIL timeout_status got %b want 01", os); end
    n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL timeout_single_pulse got %b want 0", after); end
    sel = 4'b0001; rdy = '0; valid_nt = 1'b1; pulses = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (resp_nt) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL notimeout_pulses got %0d want 0", pulses); end
    rdy = 4'b0001;
    @(posedge clk); #1;
    n_vec++; if (resp_nt !== 1'b1) begin n_err++; $display("FAIL notimeout_late_ready got %b want 1", resp_nt); end
    n_vec++; if (rd_nt !== rdata[0]) begin n_err++; $display("FAIL notimeout_data got %h want %h", rd_nt, rdata[0]); end
    valid_nt = 1'b0; rdy = '0; sel = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat; int pulses; logic [DW-1:0] od; logic [1:0] os; logic after;
    sel = 4'b0010; rdy = '0; valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    valid = 1'b0; sel = '0; pulses = 0;
    repeat (5) begin @(posedge clk); #1; if (resp) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    sel = 4'b0100; rdy = '0; valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (resp !== 1'b0 || st !== 2'b00) begin n_err++; $display("FAIL reset_midwait got ready=%b status=%b want 0/00", resp, st); end
    @(posedge clk); #1;
    valid = 1'b0; sel = '0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (resp) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL reset_pulses got %0d want 0", pulses); end
    rdata[3] = $urandom;
    drive_cmd(4'b1000, 1'b0, 2, lat, od, os, after);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL post_abort_latency got %0d want 3", lat); end
    n_vec++; if (od !== rdata[3]) begin n_err++; $display("FAIL post_abort_data got %h want %h", od, rdata[3]); end
    drive_cmd(4'b0001, 1'b0, -1, lat, od, os, after);
    n_vec++; if (lat !== TO + 1 || os !== 2'b01) begin n_err++; $display("FAIL post_abort_timeout got lat=%0d status=%b want %0d/01", lat, os, TO + 1); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v1, v2;
    v1 = $urandom; v2 = ~v1;
    rdata[2] = v1;
    sel = 4'b0100; rdy = 4'b0100; valid = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (resp !== 1'b1 || rd !== v1) begin n_err++; $display("FAIL b2b_first got ready=%b data=%h want 1/%h", resp, rd, v1); end
    rdata[2] = v2;
    @(posedge clk); #1;
    n_vec++; if (resp !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b want 0", resp); end
    @(posedge clk); #1;
    n_vec++; if (resp !== 1'b1 || rd !== v2) begin n_err++; $display("FAIL b2b_second got ready=%b data=%h want 1/%h", resp, rd, v2); end
    valid = 1'b0; sel = '0; rdy = '0;
    @(posedge clk); #1;
    n_vec++; if (resp !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", resp); end
  endtask

  task automatic test_random();
    int lat, elat, d; logic [DW-1:0] od, eod; logic [1:0] os, eos; logic after;
    logic [N-1:0] s; logic w;
    for (int t = 0; t < 60; t++) begin
      foreach (rdata[i]) rdata[i] = $urandom;
      if ($urandom_range(0, 9) < 7) s = N'(1 << $urandom_range(0, N - 1));
      else s = N'($urandom);
      w = 1'($urandom);
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 11));
      model(s, w, d, elat, eod, eos);
      drive_cmd(s, w, d, lat, od, os, after);
      n_vec++;
      if (lat !== elat || od !== eod || os !== eos || after !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d] sel=%b wr=%b d=%0d got lat=%0d data=%h st=%b after=%b want lat=%0d data=%h st=%b after=0",
                 t, s, w, d, lat, od, os, after, elat, eod, eos);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_decode_error();
    test_wait();
    test_write();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
